alu_mul_seq: RTL and testbench
==============================

Name: alu_mul_seq

Overview:
- Multi-cycle 8x8 unsigned shift-add multiply sequencer.
- Does not contain its own adder: it borrows the shared ALU for each partial-product add, using ALU_ADD from arch_defs_pkg, and reads back the registered result and carry.
- Sits beside the CPU control unit. While it owns the ALU it asserts alu_own, and a top-level mux routes its ALU drive in place of the core's.
- Produces a 16-bit product with a start/busy/done handshake.

Parameters:
- DATA_WIDTH, 8 (from arch_defs_pkg), operand width; product is 2*DATA_WIDTH.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin multiply; sampled only in IDLE
- multiplicand  in  DATA_WIDTH  operand A; captured on accepted start
- multiplier  in  DATA_WIDTH  operand B; captured on accepted start
- busy  out  1  high from the cycle after accepted start through the DONE cycle
- done  out  1  one-cycle pulse; product valid
- product  out  2*DATA_WIDTH  result; held until next accepted start
- alu_own  out  1  high while busy; selects this block as ALU driver
- alu_op  out  4  ALU_ADD always
- alu_in_one  out  DATA_WIDTH  partial-product high byte in an add-issue cycle, else 0
- alu_in_two  out  DATA_WIDTH  captured multiplicand in an add-issue cycle, else 0
- alu_in_carry  out  1  constant 0
- alu_result  in  DATA_WIDTH  ALU latched_result
- alu_carry  in  1  ALU carry_flag

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- ALU timing: the ALU registers its result. An add issued in cycle T is readable in cycle T+1.
- Internal state: ph (high byte), pl (low byte/multiplier), mc (multiplicand), cnt (0..8), fsm state.
- Reset values: state IDLE; busy=0, done=0, product=0, alu_own=0, ph=pl=mc=0, cnt=0. Reset mid-operation aborts immediately to these values; no done is produced.
- IDLE:
  - start=1: mc<=multiplicand, ph<=0, pl<=multiplier, cnt<=0, go to TEST.
  - start=0: stay.
- TEST (cnt<8):
  - pl[0]=0: {ph,pl} <= {1'b0,ph,pl}>>1; cnt++. If the new cnt is 8, go to DONE, else stay in TEST. Takes one cycle.
  - pl[0]=1: issue add (alu_in_one=ph, alu_in_two=mc); go to CAPTURE.
- CAPTURE: {ph,pl} <= {alu_carry,alu_result,pl}>>1; cnt++. Go to DONE if cnt reaches 8, else TEST.
- DONE:
  - product<={ph,pl}; done=1 for this cycle only.
  - busy stays high this cycle.
  - Next state is IDLE.
- Latency: start sampled in cycle N → done in cycle N+1+8+popcount(multiplier) (without the optional feature). Examples: multiplier=0 → N+9; multiplier=0xFF → N+17.
- start while busy is ignored, including during the DONE cycle.
- start held high in IDLE straight after DONE starts a new operation, and product updates at the next DONE.
- Overflow cannot occur: the maximum 0xFF*0xFF = 0xFE01 fits 16 bits. The carry-out of each add is shifted into ph[7].
- alu_in_one and alu_in_two are 0 in all cycles except add-issue cycles, so ALU flags written during the borrow are deterministic.
- alu_own=busy. The core must not depend on ALU flags or result across a multiply.

Optional Feature:
- Macro: MUL_SKIP_ZERO_EN.
- Defined: in TEST, if pl[7-cnt:0]==0 (all remaining multiplier bits zero), then:
  - {ph,pl} <= {ph,pl} >> (8-cnt) in one cycle;
  - cnt<=8;
  - go to DONE.
  - Latency becomes N+2 for multiplier=0; a single-add case such as multiplier=0x01 finishes at N+4.
- Not defined: the bit-serial-only behaviour above; latency is exactly 9+popcount.

Test Plan:
- Reset, then idle → product=0x0000, busy=0, done=0, alu_own=0, alu_in_one=alu_in_two=0.
- start with 0x0D*0x0B → product=0x008F, single done pulse. Without the feature, done exactly 12 cycles after start (popcount 3). busy is high for the whole interval.
- 0xFF*0xFF → product=0xFE01. Exercises alu_carry=1 shift-in; done at N+17 (feature off). alu_op=ALU_ADD and alu_in_carry=0 every cycle.
- 0x5A*0x00 → product=0x0000. Feature off: done at N+9, no add-issue cycle. Feature on: done at N+2.
- start asserted repeatedly during busy, and a second 0x03*0x07 issued on the cycle after DONE → the first product is unaffected; the second yields 0x0015.
- reset asserted mid-multiply (cycle N+5 of 0xFF*0xFF) → next cycle all outputs at reset values, no done. A fresh 0x10*0x10 then gives 0x0100.

Source files
------------

// File: rtl/alu_mul_seq.sv
// 8x8 unsigned shift-add multiplier that borrows the shared registered ALU for each partial-product add.
// Optional MUL_SKIP_ZERO_EN: finish early once all remaining multiplier bits are zero.

package arch_defs_pkg;
   localparam int         DATA_WIDTH = 8;
   localparam logic [3:0] ALU_ADD    = 4'b0010;
endpackage

// state   | meaning
// S_IDLE  | waiting for start
// S_TEST  | inspect pl[0]: shift on 0, issue ALU add on 1
// S_CAPT  | ALU sum is back; shift carry/sum into the accumulator
// S_DONE  | product valid, done pulse
module alu_mul_seq #(
   parameter int DATA_WIDTH = arch_defs_pkg::DATA_WIDTH
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [DATA_WIDTH-1:0]     multiplicand,
   input  logic [DATA_WIDTH-1:0]     multiplier,
   output logic                      busy,
   output logic                      done,
   output logic [2*DATA_WIDTH-1:0]   product,
   output logic                      alu_own,
   output logic [3:0]                alu_op,
   output logic [DATA_WIDTH-1:0]     alu_in_one,
   output logic [DATA_WIDTH-1:0]     alu_in_two,
   output logic                      alu_in_carry,
   input  logic [DATA_WIDTH-1:0]     alu_result,
   input  logic                      alu_carry
);

   localparam int              CW       = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DATA_WIDTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_TEST = 2'd1;
   localparam logic [1:0] S_CAPT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]              state, state_nxt;
   logic [DATA_WIDTH-1:0]   ph, pl, mc;
   logic [CW-1:0]           cnt, cnt_nxt;
   logic [2*DATA_WIDTH-1:0] acc_nxt;
   logic                    add_issue;
`ifdef MUL_SKIP_ZERO_EN
   logic [DATA_WIDTH-1:0]   rest_mask;
   logic [CW-1:0]           skip_shamt;
`endif

   always_comb begin
      state_nxt = state;
      acc_nxt   = {ph, pl};
      cnt_nxt   = cnt;
      add_issue = 1'b0;
`ifdef MUL_SKIP_ZERO_EN
      rest_mask  = {DATA_WIDTH{1'b1}} >> cnt;
      skip_shamt = CNT_LAST - cnt;
`endif
      case (state)
         S_IDLE: begin
            if (start) begin
               acc_nxt   = {{DATA_WIDTH{1'b0}}, multiplier};
               cnt_nxt   = '0;
               state_nxt = S_TEST;
            end
         end
         S_TEST: begin
`ifdef MUL_SKIP_ZERO_EN
            // Remaining multiplier bits all zero: the rest is pure shifting.
            if ((pl & rest_mask) == '0) begin
               acc_nxt   = {ph, pl} >> skip_shamt;
               cnt_nxt   = CNT_LAST;
               state_nxt = S_DONE;
            end else
`endif
            if (pl[0]) begin
               add_issue = 1'b1;
               state_nxt = S_CAPT;
            end else begin
               acc_nxt   = {ph, pl} >> 1;
               cnt_nxt   = cnt + 1'b1;
               state_nxt = (cnt_nxt == CNT_LAST) ? S_DONE : S_TEST;
            end
         end
         S_CAPT: begin
            // The add carry-out becomes the new top bit of the accumulator.
            acc_nxt   = {alu_carry, alu_result, pl[DATA_WIDTH-1:1]};
            cnt_nxt   = cnt + 1'b1;
            state_nxt = (cnt_nxt == CNT_LAST) ? S_DONE : S_TEST;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         ph      <= '0;
         pl      <= '0;
         mc      <= '0;
         cnt     <= '0;
         product <= '0;
      end else begin
         state    <= state_nxt;
         {ph, pl} <= acc_nxt;
         cnt      <= cnt_nxt;
         if (state == S_IDLE && start)
            mc <= multiplicand;
         // Loaded on entry to DONE so product is already valid with the done pulse.
         if (state != S_DONE && state_nxt == S_DONE)
            product <= acc_nxt;
      end
   end

   assign busy         = (state != S_IDLE);
   assign done         = (state == S_DONE);
   assign alu_own      = busy;
   assign alu_op       = arch_defs_pkg::ALU_ADD;
   assign alu_in_one   = add_issue ? ph : '0;
   assign alu_in_two   = add_issue ? mc : '0;
   assign alu_in_carry = 1'b0;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq with a registered-ALU stand-in and a cycle-level behavioural model.
// Build with MUL_SKIP_ZERO_EN defined to check the early-finish variant.

module tb_alu_mul_seq;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [7:0]  multiplicand, multiplier;
   logic        busy, done, alu_own, alu_in_carry, alu_carry;
   logic [15:0] product;
   logic [3:0]  alu_op;
   logic [7:0]  alu_in_one, alu_in_two, alu_result;

   int errors = 0;
   int checks = 0;

   alu_mul_seq dut (
      .clk(clk), .reset(reset), .start(start),
      .multiplicand(multiplicand), .multiplier(multiplier),
      .busy(busy), .done(done), .product(product), .alu_own(alu_own),
      .alu_op(alu_op), .alu_in_one(alu_in_one), .alu_in_two(alu_in_two),
      .alu_in_carry(alu_in_carry), .alu_result(alu_result), .alu_carry(alu_carry)
   );

   always #5 clk = ~clk;

   // Shared ALU stand-in: registered sum and carry.
   always @(posedge clk) begin
      {alu_carry, alu_result} <= {1'b0, alu_in_one} + {1'b0, alu_in_two} + {8'd0, alu_in_carry};
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycles from the accepting edge to the done cycle.
   function automatic int model_lat(input logic [7:0] b);
      int c;
`ifdef MUL_SKIP_ZERO_EN
      c = 0;
      for (int k = 0; k < 8; k++) begin
         if ((b >> k) == 8'd0) return c + 2;
         c += b[k] ? 2 : 1;
      end
      return c + 1;
`else
      c = 9 + $countones(b);
      return c;
`endif
   endfunction

   // Model: m_cnt counts down to the done cycle (1 = done, 0 = idle).
   int          m_cnt = 0;
   logic [15:0] m_pend = '0;
   logic [15:0] exp_prod = '0;
   bit          chk_en = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         m_cnt    = 0;
         exp_prod = '0;
      end else if (m_cnt == 0) begin
         if (start) begin
            m_pend = 16'(multiplicand) * 16'(multiplier);
            m_cnt  = model_lat(multiplier);
         end
      end else begin
         m_cnt--;
         if (m_cnt == 1) exp_prod = m_pend;
         if (m_cnt == 0) m_cnt = 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", busy, (m_cnt != 0));
         check("done", done, (m_cnt == 1));
         check("alu_own", alu_own, (m_cnt != 0));
         check("product", product, exp_prod);
         check("alu_op", alu_op, arch_defs_pkg::ALU_ADD);
         check("alu_in_carry", alu_in_carry, 1'b0);
         if (m_cnt <= 1) begin
            check("alu_in_one_quiet", alu_in_one, 8'd0);
            check("alu_in_two_quiet", alu_in_two, 8'd0);
         end
      end
   end

   task automatic wait_done(output int lat);
      lat = 0;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) lat = k;
      end
   endtask

   task automatic do_mul(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp_p, input int exp_lat);
      int lat;
      multiplicand = a;
      multiplier   = b;
      start        = 1'b1;
      wait_done(lat);
      check({name, "_lat"}, lat, exp_lat);
      check({name, "_prod"}, product, exp_p);
      check({name, "_model"}, exp_prod, exp_p);
      @(negedge clk);
      check({name, "_done_drop"}, done, 1'b0);
   endtask

   initial begin
      int lat;
      reset = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      reset  = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_product", product, 16'h0000);
      check("rst_busy", busy, 1'b0);
      check("rst_in_one", alu_in_one, 8'd0);

`ifdef MUL_SKIP_ZERO_EN
      do_mul("m0d0b", 8'h0D, 8'h0B, 16'h008F, 9);
      do_mul("mffff", 8'hFF, 8'hFF, 16'hFE01, 17);
      do_mul("m5a00", 8'h5A, 8'h00, 16'h0000, 2);
`else
      do_mul("m0d0b", 8'h0D, 8'h0B, 16'h008F, 12);
      do_mul("mffff", 8'hFF, 8'hFF, 16'hFE01, 17);
      do_mul("m5a00", 8'h5A, 8'h00, 16'h0000, 9);
`endif
      do_mul("m1234", 8'h12, 8'h34, 16'h03A8, model_lat(8'h34));

      // start held through busy and DONE; new operands presented meanwhile.
      multiplicand = 8'h0D; multiplier = 8'h0B; start = 1'b1;
      @(negedge clk);
      multiplicand = 8'h03; multiplier = 8'h07;
      lat = 0;
      for (int k = 2; k <= 40 && lat == 0; k++) begin
         @(negedge clk);
         if (done) lat = k;
      end
`ifdef MUL_SKIP_ZERO_EN
      check("b2b_first_lat", lat, 9);
`else
      check("b2b_first_lat", lat, 12);
`endif
      check("b2b_first_prod", product, 16'h008F);
      @(negedge clk);
      check("b2b_idle_prod", product, 16'h008F);
      wait_done(lat);
`ifdef MUL_SKIP_ZERO_EN
      check("b2b_second_lat", lat, 8);
`else
      check("b2b_second_lat", lat, 12);
`endif
      check("b2b_second_prod", product, 16'h0015);
      @(negedge clk);

      // Reset in cycle N+5 of 0xFF*0xFF.
      multiplicand = 8'hFF; multiplier = 8'hFF; start = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_own", alu_own, 1'b0);
      check("abort_prod", product, 16'h0000);
      repeat (15) @(negedge clk);
      check("abort_no_done", done, 1'b0);
      check("abort_prod_held", product, 16'h0000);
`ifdef MUL_SKIP_ZERO_EN
      do_mul("m1010", 8'h10, 8'h10, 16'h0100, 8);
`else
      do_mul("m1010", 8'h10, 8'h10, 16'h0100, 10);
`endif

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
